qpu_lsu_ctrl_mb: RTL and testbench
==================================

# qpu_lsu_ctrl_mb

Parametrised multi-bank LSU controller for the QPU: accepts AGU ICB commands, routes each to one of NBANK address-interleaved DTCM banks, and tracks up to OUTS outstanding accesses in an in-order tag FIFO so write-backs retire in issue order.
- It detects misaligned accesses locally and retires them as error write-backs without touching any bank.
- It returns the bank read data (not the write data) on the write-back port.
- It sits between the AGU and the banked DTCM, in the same position as the single-bank LSU control.

## Interface
Parameters:
- XLEN, 32, data width; LB = log2(XLEN/8).
- ADDR_W, 32, AGU address width.
- ITAG_W, 4, instruction tag width.
- DTCM_AW, 16, DTCM byte-address width.
- NBANK, 2, bank count; power of two, ≥2; BW = log2(NBANK).
- OUTS, 4, max outstanding accesses; ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- lsu_ctrl_active  out  1  agu_icb_cmd_valid | (count != 0).
- agu_icb_cmd_valid / agu_icb_cmd_ready  in / out  1  AGU command handshake.
- agu_icb_cmd_addr  in  ADDR_W  byte address.
- agu_icb_cmd_read  in  1  1 = load, 0 = store.
- agu_icb_cmd_size  in  2  0 byte, 1 half, 2 word; 3 is treated as misaligned.
- agu_icb_cmd_wdata  in  XLEN  store data.
- agu_icb_cmd_wmask  in  XLEN/8  byte mask.
- agu_icb_cmd_itag  in  ITAG_W  tag.
- dtcm_icb_cmd_valid  out  NBANK  per-bank command valid.
- dtcm_icb_cmd_ready  in  NBANK  per-bank command ready.
- dtcm_icb_cmd_addr  out  DTCM_AW-LB-BW  bank word address, broadcast to all banks.
- dtcm_icb_cmd_read  out  1  broadcast.
- dtcm_icb_cmd_wdata  out  XLEN  broadcast.
- dtcm_icb_cmd_wmask  out  XLEN/8  broadcast.
- dtcm_icb_rsp_valid / dtcm_icb_rsp_ready  in / out  NBANK  per-bank response handshake.
- dtcm_icb_rsp_rdata  in  NBANK*XLEN  bank b occupies bits [b*XLEN +: XLEN].
- lsu_o_valid / lsu_o_ready  out / in  1  write-back handshake.
- lsu_o_wbck_wdat  out  XLEN  load data; 0 for stores and errors.
- lsu_o_wbck_itag  out  ITAG_W  tag of head entry.
- lsu_o_cmt_badaddr  out  ADDR_W  address of head entry.
- lsu_o_cmt_ld / lsu_o_cmt_st  out  1  head is a load / head is a store.
- lsu_o_cmt_misalgn  out  1  head entry is a misaligned error.

## Operation
Decode and routing:
- sel = addr[LB+BW-1:LB]; bank addr = addr[DTCM_AW-1:LB+BW].
- mis = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (size==3).

Tracking FIFO:
- OUTS entries, each {read, mis, sel, itag, addr}.
- Write/read pointers wrap modulo OUTS; count ranges 0..OUTS.

Command path:
- pop = lsu_o_valid & lsu_o_ready.
- room = (count < OUTS) | pop.
- dtcm_icb_cmd_valid[b] = agu_icb_cmd_valid & room & ~mis & (sel==b).
- agu_icb_cmd_ready = room & (mis | dtcm_icb_cmd_ready[sel]).
- push = agu_icb_cmd_valid & agu_icb_cmd_ready. A misaligned command is pushed with no bank command issued.

Response path, strictly in order; head = entry at the read pointer:
- Head misaligned: lsu_o_valid = 1 and every dtcm_icb_rsp_ready = 0.
- Head normal with bank h: lsu_o_valid = dtcm_icb_rsp_valid[h]; dtcm_icb_rsp_ready[h] = lsu_o_ready; every other bank's rsp_ready = 0, so a response from a non-head bank stalls in that bank.
- FIFO empty: lsu_o_valid = 0 and all rsp_ready = 0.
- lsu_o_wbck_wdat = rdata[h] when the head is a normal load, else 0.
- itag, badaddr, ld (= read), st (= ~read) and misalgn are taken from the head entry; all are 0 when the FIFO is empty.
- Push and pop in the same cycle leave count unchanged and advance both pointers.

## Timing
Reset (rst high at a rising edge):
- Pointers and count clear to 0; FIFO contents are don't-care.
- After reset: lsu_o_valid = 0, all dtcm_icb_rsp_ready = 0, all head-derived outputs = 0, agu_icb_cmd_ready follows the selected bank ready (room = 1).
- Reset mid-operation discards all outstanding entries. Bank responses arriving later are ignored because rsp_ready stays 0 while the FIFO is empty.

Latency and paths:
- AGU to bank: combinational, 0 cycles.
- Bank response to lsu_o: combinational, 0 cycles.
- Misaligned write-back: lsu_o_valid no earlier than the cycle after push.
- Combinational path lsu_o_ready → pop → agu_icb_cmd_ready / dtcm_icb_cmd_valid exists by design; it allows a push at full in the same cycle as a pop.

Handshake rules:
- lsu_o_valid and head data stay stable until lsu_o_ready is seen, provided the bank holds rsp_valid and rdata.
- Throughput: 1 command and 1 write-back per cycle.

## Test plan
- Back-to-back loads to 0x0, 0x4, 0x8, 0xC with NBANK=2 → banks 0, 1, 0, 1 receive word addresses 0, 0, 1, 1; write-backs retire in itag order 0..3 with the correct rdata.
- Bank 1 responds before bank 0, with head in bank 0 → dtcm_icb_rsp_ready[1] = 0 until bank 0's write-back retires; then bank 1's data is written back next.
- Word load at 0x6 between two valid loads → no bank command for it; lsu_o_cmt_misalgn = 1, badaddr = 0x6, wdat = 0, retired between the two valid loads.
- Issue OUTS = 4 loads with lsu_o_ready = 0 → agu_icb_cmd_ready = 0 on the 5th. Then assert lsu_o_ready → the 5th command is accepted in the same cycle as the pop, and count stays 4.
- Store of 0xDEADBEEF with wmask 0xF → the bank sees wdata 0xDEADBEEF and read = 0; the write-back has st = 1, ld = 0, wdat = 0.
- Assert rst with 3 entries outstanding → the next cycle shows lsu_o_valid = 0 and lsu_ctrl_active = 0 with agu_icb_cmd_valid low; a late bank response is not accepted (rsp_ready = 0).

Source files
------------

// File: rtl/qpu_lsu_ctrl_mb.sv
// Multi-bank LSU controller: routes AGU commands to address-interleaved DTCM banks
// and retires write-backs in issue order through a small tag FIFO.
module qpu_lsu_ctrl_mb #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int ITAG_W  = 4,
  parameter int DTCM_AW = 16,
  parameter int NBANK   = 2,
  parameter int OUTS    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  output logic                                          lsu_ctrl_active,
  input  logic                                          agu_icb_cmd_valid,
  output logic                                          agu_icb_cmd_ready,
  input  logic [ADDR_W-1:0]                             agu_icb_cmd_addr,
  input  logic                                          agu_icb_cmd_read,
  input  logic [1:0]                                    agu_icb_cmd_size,
  input  logic [XLEN-1:0]                               agu_icb_cmd_wdata,
  input  logic [XLEN/8-1:0]                             agu_icb_cmd_wmask,
  input  logic [ITAG_W-1:0]                             agu_icb_cmd_itag,
  output logic [NBANK-1:0]                              dtcm_icb_cmd_valid,
  input  logic [NBANK-1:0]                              dtcm_icb_cmd_ready,
  output logic [DTCM_AW-$clog2(XLEN/8)-$clog2(NBANK)-1:0] dtcm_icb_cmd_addr,
  output logic                                          dtcm_icb_cmd_read,
  output logic [XLEN-1:0]                               dtcm_icb_cmd_wdata,
  output logic [XLEN/8-1:0]                             dtcm_icb_cmd_wmask,
  input  logic [NBANK-1:0]                              dtcm_icb_rsp_valid,
  output logic [NBANK-1:0]                              dtcm_icb_rsp_ready,
  input  logic [NBANK*XLEN-1:0]                         dtcm_icb_rsp_rdata,
  output logic                                          lsu_o_valid,
  input  logic                                          lsu_o_ready,
  output logic [XLEN-1:0]                               lsu_o_wbck_wdat,
  output logic [ITAG_W-1:0]                             lsu_o_wbck_itag,
  output logic [ADDR_W-1:0]                             lsu_o_cmt_badaddr,
  output logic                                          lsu_o_cmt_ld,
  output logic                                          lsu_o_cmt_st,
  output logic                                          lsu_o_cmt_misalgn
);

  localparam int LB = $clog2(XLEN/8);
  localparam int BW = $clog2(NBANK);
  localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW = $clog2(OUTS + 1);

  logic              r_fRead [OUTS];
  logic              r_fMis  [OUTS];
  logic [BW-1:0]     r_fSel  [OUTS];
  logic [ITAG_W-1:0] r_fItag [OUTS];
  logic [ADDR_W-1:0] r_fAddr [OUTS];

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;

  logic            w_mis;
  logic [BW-1:0]   w_sel;
  logic            w_hasHead;
  logic            w_headRead;
  logic            w_headMis;
  logic [BW-1:0]   w_headSel;
  logic            w_push;
  logic            w_pop;
  logic            w_room;
  logic [XLEN-1:0] w_rdata [NBANK];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_sel = agu_icb_cmd_addr[LB+BW-1:LB];
  assign w_mis = ((agu_icb_cmd_size == 2'd1) & agu_icb_cmd_addr[0])
               | ((agu_icb_cmd_size == 2'd2) & (agu_icb_cmd_addr[1:0] != 2'b00))
               |  (agu_icb_cmd_size == 2'd3);

  assign w_hasHead  = (r_count != '0);
  assign w_headRead = r_fRead[r_rdPtr];
  assign w_headMis  = r_fMis[r_rdPtr];
  assign w_headSel  = r_fSel[r_rdPtr];

  assign lsu_o_valid = w_hasHead & (w_headMis | dtcm_icb_rsp_valid[w_headSel]);
  assign w_pop       = lsu_o_valid & lsu_o_ready;
  // A pop in this cycle frees a slot, so a full FIFO can still accept a command.
  assign w_room      = (r_count < CW'(OUTS)) | w_pop;

  assign agu_icb_cmd_ready = w_room & (w_mis | dtcm_icb_cmd_ready[w_sel]);
  assign w_push            = agu_icb_cmd_valid & agu_icb_cmd_ready;
  assign lsu_ctrl_active   = agu_icb_cmd_valid | w_hasHead;

  assign dtcm_icb_cmd_addr  = agu_icb_cmd_addr[DTCM_AW-1:LB+BW];
  assign dtcm_icb_cmd_read  = agu_icb_cmd_read;
  assign dtcm_icb_cmd_wdata = agu_icb_cmd_wdata;
  assign dtcm_icb_cmd_wmask = agu_icb_cmd_wmask;

  always_comb begin
    dtcm_icb_cmd_valid = '0;
    dtcm_icb_rsp_ready = '0;
    for (int b = 0; b < NBANK; b++) begin
      w_rdata[b] = dtcm_icb_rsp_rdata[b*XLEN +: XLEN];
      dtcm_icb_cmd_valid[b] = agu_icb_cmd_valid & w_room & ~w_mis & (w_sel == BW'(b));
    end
    // Only the head's bank may hand over its response; others stall in place.
    if (w_hasHead & ~w_headMis) begin
      dtcm_icb_rsp_ready[w_headSel] = lsu_o_ready;
    end
  end

  assign lsu_o_wbck_wdat   = (w_hasHead & w_headRead & ~w_headMis) ? w_rdata[w_headSel] : '0;
  assign lsu_o_wbck_itag   = w_hasHead ? r_fItag[r_rdPtr] : '0;
  assign lsu_o_cmt_badaddr = w_hasHead ? r_fAddr[r_rdPtr] : '0;
  assign lsu_o_cmt_ld      = w_hasHead & w_headRead;
  assign lsu_o_cmt_st      = w_hasHead & ~w_headRead;
  assign lsu_o_cmt_misalgn = w_hasHead & w_headMis;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fRead[r_wrPtr] <= agu_icb_cmd_read;
      r_fMis[r_wrPtr]  <= w_mis;
      r_fSel[r_wrPtr]  <= w_sel;
      r_fItag[r_wrPtr] <= agu_icb_cmd_itag;
      r_fAddr[r_wrPtr] <= agu_icb_cmd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_qpu_lsu_ctrl_mb.sv
// Scoreboard bench for qpu_lsu_ctrl_mb: directed commands, a two-bank DTCM model and
// an in-order write-back monitor.
module tb_qpu_lsu_ctrl_mb;

  typedef struct packed {
    logic [31:0] wdat;
    logic [3:0]  itag;
    logic [31:0] addr;
    logic        ld;
    logic        st;
    logic        mis;
  } wb_t;

  typedef struct packed {
    logic        bank;
    logic [12:0] waddr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_ctrl_active;
  logic        agu_icb_cmd_valid;
  logic        agu_icb_cmd_ready;
  logic [31:0] agu_icb_cmd_addr;
  logic        agu_icb_cmd_read;
  logic [1:0]  agu_icb_cmd_size;
  logic [31:0] agu_icb_cmd_wdata;
  logic [3:0]  agu_icb_cmd_wmask;
  logic [3:0]  agu_icb_cmd_itag;
  logic [1:0]  dtcm_icb_cmd_valid;
  logic [1:0]  dtcm_icb_cmd_ready;
  logic [12:0] dtcm_icb_cmd_addr;
  logic        dtcm_icb_cmd_read;
  logic [31:0] dtcm_icb_cmd_wdata;
  logic [3:0]  dtcm_icb_cmd_wmask;
  logic [1:0]  dtcm_icb_rsp_valid;
  logic [1:0]  dtcm_icb_rsp_ready;
  logic [63:0] dtcm_icb_rsp_rdata;
  logic        lsu_o_valid;
  logic        lsu_o_ready;
  logic [31:0] lsu_o_wbck_wdat;
  logic [3:0]  lsu_o_wbck_itag;
  logic [31:0] lsu_o_cmt_badaddr;
  logic        lsu_o_cmt_ld;
  logic        lsu_o_cmt_st;
  logic        lsu_o_cmt_misalgn;

  logic [1:0]  bankEn;
  int          compared = 0;
  int          mismatched = 0;
  wb_t         wbQ[$];
  bc_t         cmdQ[$];
  logic [31:0] rspQ0[$];
  logic [31:0] rspQ1[$];

  qpu_lsu_ctrl_mb dut (
    .clk(clk), .rst(rst), .lsu_ctrl_active(lsu_ctrl_active),
    .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
    .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
    .agu_icb_cmd_size(agu_icb_cmd_size), .agu_icb_cmd_wdata(agu_icb_cmd_wdata),
    .agu_icb_cmd_wmask(agu_icb_cmd_wmask), .agu_icb_cmd_itag(agu_icb_cmd_itag),
    .dtcm_icb_cmd_valid(dtcm_icb_cmd_valid), .dtcm_icb_cmd_ready(dtcm_icb_cmd_ready),
    .dtcm_icb_cmd_addr(dtcm_icb_cmd_addr), .dtcm_icb_cmd_read(dtcm_icb_cmd_read),
    .dtcm_icb_cmd_wdata(dtcm_icb_cmd_wdata), .dtcm_icb_cmd_wmask(dtcm_icb_cmd_wmask),
    .dtcm_icb_rsp_valid(dtcm_icb_rsp_valid), .dtcm_icb_rsp_ready(dtcm_icb_rsp_ready),
    .dtcm_icb_rsp_rdata(dtcm_icb_rsp_rdata),
    .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
    .lsu_o_wbck_wdat(lsu_o_wbck_wdat), .lsu_o_wbck_itag(lsu_o_wbck_itag),
    .lsu_o_cmt_badaddr(lsu_o_cmt_badaddr), .lsu_o_cmt_ld(lsu_o_cmt_ld),
    .lsu_o_cmt_st(lsu_o_cmt_st), .lsu_o_cmt_misalgn(lsu_o_cmt_misalgn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Write-back monitor: every retired write-back must match the oldest expectation.
  always @(negedge clk) begin
    wb_t act;
    wb_t exp;
    if (!rst && lsu_o_valid && lsu_o_ready) begin
      act = '{wdat: lsu_o_wbck_wdat, itag: lsu_o_wbck_itag, addr: lsu_o_cmt_badaddr,
              ld: lsu_o_cmt_ld, st: lsu_o_cmt_st, mis: lsu_o_cmt_misalgn};
      compared++;
      if (wbQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL wb_unexpected: got %h, expected nothing", act);
      end else begin
        exp = wbQ.pop_front();
        if (act !== exp) begin
          mismatched++;
          $display("[TB] FAIL wb_itag%0d: got %h, expected %h", exp.itag, act, exp);
        end
      end
    end
  end

  // Bank model: checks routed commands, answers loads one cycle later with a pattern word.
  always @(negedge clk) begin
    bc_t a;
    bc_t e;
    logic [31:0] d;
    if (dtcm_icb_rsp_valid[0] && dtcm_icb_rsp_ready[0] && rspQ0.size() != 0) void'(rspQ0.pop_front());
    if (dtcm_icb_rsp_valid[1] && dtcm_icb_rsp_ready[1] && rspQ1.size() != 0) void'(rspQ1.pop_front());
    for (int b = 0; b < 2; b++) begin
      if (dtcm_icb_cmd_valid[b] && dtcm_icb_cmd_ready[b]) begin
        a = '{bank: 1'(b), waddr: dtcm_icb_cmd_addr, read: dtcm_icb_cmd_read,
              wdata: dtcm_icb_cmd_wdata, wmask: dtcm_icb_cmd_wmask};
        compared++;
        if (cmdQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL bank_cmd_unexpected: got %h, expected nothing", a);
        end else begin
          e = cmdQ.pop_front();
          if (a !== e) begin
            mismatched++;
            $display("[TB] FAIL bank_cmd: got %h, expected %h", a, e);
          end
        end
        d = dtcm_icb_cmd_read ? (32'hB000_0000 | (32'(b) << 24) | 32'(dtcm_icb_cmd_addr))
                              : 32'hFFFF_FFFF;
        if (b == 0) rspQ0.push_back(d);
        else        rspQ1.push_back(d);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    dtcm_icb_rsp_valid[0]     = bankEn[0] && (rspQ0.size() != 0);
    dtcm_icb_rsp_valid[1]     = bankEn[1] && (rspQ1.size() != 0);
    dtcm_icb_rsp_rdata[31:0]  = (rspQ0.size() != 0) ? rspQ0[0] : 32'h0;
    dtcm_icb_rsp_rdata[63:32] = (rspQ1.size() != 0) ? rspQ1[0] : 32'h0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveCmd(input logic [31:0] addr, input logic [1:0] size, input logic read,
                          input logic [31:0] wdata, input logic [3:0] itag, input logic mis,
                          input logic bank, input logic [12:0] waddr, input logic [31:0] expDat);
    @(posedge clk);
    #1;
    wbQ.push_back('{wdat: expDat, itag: itag, addr: addr, ld: read, st: ~read, mis: mis});
    if (!mis) cmdQ.push_back('{bank: bank, waddr: waddr, read: read, wdata: wdata, wmask: 4'hF});
    agu_icb_cmd_valid = 1'b1;
    agu_icb_cmd_addr  = addr;
    agu_icb_cmd_size  = size;
    agu_icb_cmd_read  = read;
    agu_icb_cmd_wdata = wdata;
    agu_icb_cmd_wmask = 4'hF;
    agu_icb_cmd_itag  = itag;
  endtask

  task automatic waitAccept();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (agu_icb_cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got ready=0 for 50 cycles, expected ready=1");
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] size, input logic read,
                               input logic [31:0] wdata, input logic [3:0] itag, input logic mis,
                               input logic bank, input logic [12:0] waddr, input logic [31:0] expDat);
    driveCmd(addr, size, read, wdata, itag, mis, bank, waddr, expDat);
    waitAccept();
  endtask

  task automatic idleCmd();
    @(posedge clk);
    #1;
    agu_icb_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wbQ.size() == 0 && cmdQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_drain: got %0d pending, expected 0", name, wbQ.size());
    end
    @(negedge clk);
    checkOutput({name, "_idle"}, 32'(lsu_ctrl_active), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    agu_icb_cmd_valid = 1'b0;
    agu_icb_cmd_addr = '0;
    agu_icb_cmd_read = 1'b0;
    agu_icb_cmd_size = '0;
    agu_icb_cmd_wdata = '0;
    agu_icb_cmd_wmask = '0;
    agu_icb_cmd_itag = '0;
    dtcm_icb_cmd_ready = 2'b11;
    dtcm_icb_rsp_valid = '0;
    dtcm_icb_rsp_rdata = '0;
    lsu_o_ready = 1'b1;
    bankEn = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_valid",   32'(lsu_o_valid), 32'h0);
    checkOutput("rst_active",  32'(lsu_ctrl_active), 32'h0);
    checkOutput("rst_rspRdy",  32'(dtcm_icb_rsp_ready), 32'h0);
    checkOutput("rst_itag",    32'(lsu_o_wbck_itag), 32'h0);
    checkOutput("rst_badaddr", lsu_o_cmt_badaddr, 32'h0);
    checkOutput("rst_flags",   32'({lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_cmt_misalgn}), 32'h0);
    checkOutput("rst_wdat",    lsu_o_wbck_wdat, 32'h0);

    // Ready must follow the selected bank's ready while the FIFO has room.
    @(posedge clk);
    #1;
    dtcm_icb_cmd_ready = 2'b01;
    agu_icb_cmd_valid = 1'b1;
    agu_icb_cmd_addr = 32'h4;
    agu_icb_cmd_size = 2'd2;
    agu_icb_cmd_read = 1'b1;
    @(negedge clk);
    checkOutput("rdy_bank1_busy", 32'(agu_icb_cmd_ready), 32'h0);
    checkOutput("cmdvalid_bank1", 32'(dtcm_icb_cmd_valid), 32'h2);
    checkOutput("active_cmd",     32'(lsu_ctrl_active), 32'h1);
    #2 dtcm_icb_cmd_ready = 2'b11;
    #1 checkOutput("rdy_bank1_free", 32'(agu_icb_cmd_ready), 32'h1);
    agu_icb_cmd_valid = 1'b0;

    $display("[TB] back-to-back interleaved loads");
    applyStimulus(32'h0, 2'd2, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0, 13'd0, 32'hB000_0000);
    applyStimulus(32'h4, 2'd2, 1'b1, 32'h0, 4'd1, 1'b0, 1'b1, 13'd0, 32'hB100_0000);
    applyStimulus(32'h8, 2'd2, 1'b1, 32'h0, 4'd2, 1'b0, 1'b0, 13'd1, 32'hB000_0001);
    applyStimulus(32'hC, 2'd2, 1'b1, 32'h0, 4'd3, 1'b0, 1'b1, 13'd1, 32'hB100_0001);
    idleCmd();
    drain("b2b");

    $display("[TB] non-head bank answers first");
    bankEn = 2'b10;
    applyStimulus(32'h10, 2'd2, 1'b1, 32'h0, 4'd4, 1'b0, 1'b0, 13'd2, 32'hB000_0002);
    applyStimulus(32'h14, 2'd2, 1'b1, 32'h0, 4'd5, 1'b0, 1'b1, 13'd2, 32'hB100_0002);
    idleCmd();
    repeat (3) @(negedge clk);
    checkOutput("ooo_rspRdy", 32'(dtcm_icb_rsp_ready), 32'h1);
    checkOutput("ooo_valid",  32'(lsu_o_valid), 32'h0);
    bankEn = 2'b11;
    drain("ooo");

    $display("[TB] misaligned and size boundaries");
    applyStimulus(32'h20, 2'd2, 1'b1, 32'h0, 4'd6,  1'b0, 1'b0, 13'd4, 32'hB000_0004);
    applyStimulus(32'h6,  2'd2, 1'b1, 32'h0, 4'd7,  1'b1, 1'b0, 13'd0, 32'h0);
    applyStimulus(32'h24, 2'd2, 1'b1, 32'h0, 4'd8,  1'b0, 1'b1, 13'd4, 32'hB100_0004);
    applyStimulus(32'h1,  2'd1, 1'b1, 32'h0, 4'd9,  1'b1, 1'b0, 13'd0, 32'h0);
    applyStimulus(32'h0,  2'd3, 1'b1, 32'h0, 4'd10, 1'b1, 1'b0, 13'd0, 32'h0);
    applyStimulus(32'h2,  2'd1, 1'b1, 32'h0, 4'd11, 1'b0, 1'b0, 13'd0, 32'hB000_0000);
    applyStimulus(32'h3,  2'd0, 1'b1, 32'h0, 4'd12, 1'b0, 1'b0, 13'd0, 32'hB000_0000);
    applyStimulus(32'h1A, 2'd1, 1'b1, 32'h0, 4'd13, 1'b0, 1'b0, 13'd3, 32'hB000_0003);
    idleCmd();
    drain("mis");

    $display("[TB] store");
    applyStimulus(32'h60, 2'd2, 1'b0, 32'hDEAD_BEEF, 4'd14, 1'b0, 1'b0, 13'd12, 32'h0);
    idleCmd();
    drain("st");

    $display("[TB] full FIFO with same-cycle push and pop");
    lsu_o_ready = 1'b0;
    applyStimulus(32'h30, 2'd2, 1'b1, 32'h0, 4'd0, 1'b0, 1'b0, 13'd6, 32'hB000_0006);
    applyStimulus(32'h34, 2'd2, 1'b1, 32'h0, 4'd1, 1'b0, 1'b1, 13'd6, 32'hB100_0006);
    applyStimulus(32'h38, 2'd2, 1'b1, 32'h0, 4'd2, 1'b0, 1'b0, 13'd7, 32'hB000_0007);
    applyStimulus(32'h3C, 2'd2, 1'b1, 32'h0, 4'd3, 1'b0, 1'b1, 13'd7, 32'hB100_0007);
    driveCmd(32'h40, 2'd2, 1'b1, 32'h0, 4'd4, 1'b0, 1'b0, 13'd8, 32'hB000_0008);
    @(negedge clk);
    checkOutput("full_rdy_a", 32'(agu_icb_cmd_ready), 32'h0);
    @(negedge clk);
    checkOutput("full_rdy_b", 32'(agu_icb_cmd_ready), 32'h0);
    @(posedge clk);
    #1 lsu_o_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_push_pop_rdy", 32'(agu_icb_cmd_ready), 32'h1);
    driveCmd(32'h44, 2'd2, 1'b1, 32'h0, 4'd5, 1'b0, 1'b1, 13'd8, 32'hB100_0008);
    lsu_o_ready = 1'b0;
    @(negedge clk);
    checkOutput("still_full_rdy", 32'(agu_icb_cmd_ready), 32'h0);
    @(posedge clk);
    #1 lsu_o_ready = 1'b1;
    waitAccept();
    idleCmd();
    drain("full");

    $display("[TB] reset with entries outstanding");
    lsu_o_ready = 1'b0;
    bankEn = 2'b00;
    applyStimulus(32'h50, 2'd2, 1'b1, 32'h0, 4'd6, 1'b0, 1'b0, 13'd10, 32'hB000_000A);
    applyStimulus(32'h54, 2'd2, 1'b1, 32'h0, 4'd7, 1'b0, 1'b1, 13'd10, 32'hB100_000A);
    applyStimulus(32'h58, 2'd2, 1'b1, 32'h0, 4'd8, 1'b0, 1'b0, 13'd11, 32'hB000_000B);
    idleCmd();
    @(posedge clk);
    #1 rst = 1'b1;
    wbQ.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst2_valid",  32'(lsu_o_valid), 32'h0);
    checkOutput("rst2_active", 32'(lsu_ctrl_active), 32'h0);
    checkOutput("rst2_rspRdy", 32'(dtcm_icb_rsp_ready), 32'h0);
    bankEn = 2'b11;
    @(posedge clk);
    #1 lsu_o_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("late_rsp_rdy",   32'(dtcm_icb_rsp_ready), 32'h0);
      checkOutput("late_rsp_valid", 32'(lsu_o_valid), 32'h0);
    end
    checkOutput("cmdq_left", 32'(cmdQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
